mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Memory-side responder for the multi-cycle MIPS datapath.
- Answers every address the controller drives (PC or ALUOut, selected by i_or_d):
  - word-addressed RAM,
  - two memory-mapped input ports,
  - one memory-mapped output port.
- Registered read path with fixed 1-cycle latency, matching the controller's FETCH1->FETCH2 and MEM_ACCESS->MEM_READ_COMP sequencing.
- Write commits on the edge where mem_write is high.

Parameters:
- WIDTH, 32, data and address width in bits.
- RAM_ADDR_BITS, 8, RAM word-address bits; RAM depth = 2**RAM_ADDR_BITS words.
- INPORT0_ADDR, 32'h0000_FFF8, byte address of input port 0 (read-only).
- INPORT1_ADDR, 32'h0000_FFFC, byte address of input port 1 (read) and output port (write).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- addr  in  WIDTH  byte address from datapath address mux
- wr_data  in  WIDTH  store data (datapath reg B)
- mem_write  in  1  write strobe, sampled at clk edge
- rd_data  out  WIDTH  registered read data
- inport0_data  in  WIDTH  external input value for port 0
- inport0_en  in  1  load enable for port 0 holding register
- inport1_data  in  WIDTH  external input value for port 1
- inport1_en  in  1  load enable for port 1 holding register
- outport  out  WIDTH  output port register
- access_err  out  1  sticky error flag: misaligned or unmapped access

Behaviour:
- Reset (sync, rst=1 at edge):
  - rd_data=0, outport=0, access_err=0.
  - inport0/inport1 holding registers = 0.
  - Read-select register = RAM.
  - RAM contents not cleared.
  - A write presented in a reset cycle is suppressed.
- Decode (combinational on addr):
  - RAM hit when addr[WIDTH-1:RAM_ADDR_BITS+2]==0; word index = addr[RAM_ADDR_BITS+1:2].
  - INPORT0 hit when addr==INPORT0_ADDR.
  - INPORT1/OUTPORT hit when addr==INPORT1_ADDR.
  - Anything else is unmapped.
- Misalignment:
  - addr[1:0]!=0 means addr[1:0] is ignored for decode; access proceeds on the word.
  - access_err is set on the next edge.
- Reads:
  - Every cycle is a read; there is no read strobe.
  - addr presented in cycle N gives rd_data in cycle N+1, held until the next edge.
  - The edge registers the RAM word or the port holding-register value for the port selected in cycle N (no combinational path from addr to rd_data).
  - Unmapped read returns 0 and sets access_err.
- Writes (mem_write=1 at edge):
  - RAM hit: the word is written.
  - INPORT1_ADDR: outport <= wr_data.
  - INPORT0_ADDR: ignored, no error.
  - Unmapped: ignored, access_err set.
- Read/write same cycle, same RAM word: read-before-write. rd_data in N+1 shows the old word; a read in N+1 sees the new word.
- Input ports:
  - Holding register loads its *_data on the edge where *_en=1; otherwise it holds.
  - A read of a port address in the same cycle that en is asserted returns the pre-load value.
- outport changes only on a qualifying write; it holds otherwise.
- access_err is sticky; only rst clears it.
- Simultaneous events:
  - inport load and a port read in the same cycle follow the rule above.
  - A write to INPORT1_ADDR reads back inport1, never outport.
- No internal FSM beyond the registered read-select and data path.
- The block never stalls; it has no ready or valid signal.

Test Plan:
- Reset, then drive addr=0x0, mem_write=0 for 2 cycles -> rd_data=0, outport=0, access_err=0.
- Write 0xDEADBEEF to addr=0x10, then read addr=0x10 -> rd_data=0xDEADBEEF exactly 1 cycle after addr applied. Same-cycle write 0x12345678 plus read of 0x10 -> next cycle 0xDEADBEEF, following cycle 0x12345678.
- inport0_data=0xA5, inport0_en=1 for one cycle, then en=0 and data=0xFF; read 0xFFF8 -> rd_data=0xA5. Repeat for port 1 at 0xFFFC with 0x3C.
- mem_write=1, addr=0xFFFC, wr_data=0x55 -> outport=0x55 after the edge. Read 0xFFFC next -> rd_data=inport1 value, not 0x55. Write to 0xFFF8 -> outport unchanged, access_err=0.
- Read addr=0x2000 (unmapped) -> rd_data=0, access_err=1, and it stays 1 across later valid accesses until rst. Access addr=0x12 -> word 0x10 accessed and access_err=1.
- Assert rst in the same cycle as mem_write=1 to addr=0x20, wr_data=0x99 -> RAM[0x20] keeps its prior value, rd_data=0, outport=0.

Source files
------------

// File: rtl/mem_io_responder.sv
// Memory-side responder for the multi-cycle MIPS datapath: word RAM plus
// two memory-mapped input ports and one output port, with a 1-cycle registered read.
module mem_io_responder #(
  parameter int unsigned          WIDTH         = 32,
  parameter int unsigned          RAM_ADDR_BITS = 8,
  parameter logic [WIDTH-1:0]     INPORT0_ADDR  = 32'h0000_FFF8,
  parameter logic [WIDTH-1:0]     INPORT1_ADDR  = 32'h0000_FFFC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             mem_write,
  output logic [WIDTH-1:0] rd_data,
  input  logic [WIDTH-1:0] inport0_data,
  input  logic             inport0_en,
  input  logic [WIDTH-1:0] inport1_data,
  input  logic             inport1_en,
  output logic [WIDTH-1:0] outport,
  output logic             access_err
);

  localparam int unsigned DEPTH = 1 << RAM_ADDR_BITS;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_IN0,
    SEL_IN1,
    SEL_NONE
  } sel_e;

  logic [WIDTH-1:0]         mem [DEPTH];
  logic [WIDTH-1:0]         word_addr;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  sel_e                     sel;

  logic [WIDTH-1:0] rd_data_d,  rd_data_q;
  logic [WIDTH-1:0] inport0_d,  inport0_q;
  logic [WIDTH-1:0] inport1_d,  inport1_q;
  logic [WIDTH-1:0] outport_d,  outport_q;
  logic             access_err_d, access_err_q;

  // Byte offset is dropped before decode so misaligned accesses hit the word.
  always_comb begin
    word_addr = {addr[WIDTH-1:2], 2'b00};
    ram_idx   = addr[RAM_ADDR_BITS+1:2];
    sel       = SEL_NONE;
    if (addr[WIDTH-1:RAM_ADDR_BITS+2] == '0) begin
      sel = SEL_RAM;
    end else if (word_addr == INPORT0_ADDR) begin
      sel = SEL_IN0;
    end else if (word_addr == INPORT1_ADDR) begin
      sel = SEL_IN1;
    end
  end

  // Reads use the pre-edge RAM word and holding-register values, giving
  // read-before-write and pre-load semantics without extra bypass logic.
  always_comb begin
    rd_data_d = '0;
    unique case (sel)
      SEL_RAM:  rd_data_d = mem[ram_idx];
      SEL_IN0:  rd_data_d = inport0_q;
      SEL_IN1:  rd_data_d = inport1_q;
      SEL_NONE: rd_data_d = '0;
    endcase

    inport0_d    = inport0_en ? inport0_data : inport0_q;
    inport1_d    = inport1_en ? inport1_data : inport1_q;
    outport_d    = (mem_write && sel == SEL_IN1) ? wr_data : outport_q;
    access_err_d = access_err_q | (addr[1:0] != 2'b00) | (sel == SEL_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q    <= '0;
      inport0_q    <= '0;
      inport1_q    <= '0;
      outport_q    <= '0;
      access_err_q <= 1'b0;
    end else begin
      rd_data_q    <= rd_data_d;
      inport0_q    <= inport0_d;
      inport1_q    <= inport1_d;
      outport_q    <= outport_d;
      access_err_q <= access_err_d;
    end
  end

  // RAM has no reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_write && sel == SEL_RAM) begin
      mem[ram_idx] <= wr_data;
    end
  end

  assign rd_data    = rd_data_q;
  assign outport    = outport_q;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a reference model predicts each read,
// the prediction is queued when driven and compared one edge later.
module tb_mem_io_responder;

  localparam logic [31:0] IN0 = 32'h0000_FFF8;
  localparam logic [31:0] IN1 = 32'h0000_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        mem_write;
  logic [31:0] rd_data;
  logic [31:0] inport0_data;
  logic        inport0_en;
  logic [31:0] inport1_data;
  logic        inport1_en;
  logic [31:0] outport;
  logic        access_err;

  always #5 clk = ~clk;

  mem_io_responder #(
    .WIDTH(32),
    .RAM_ADDR_BITS(8),
    .INPORT0_ADDR(IN0),
    .INPORT1_ADDR(IN1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .wr_data(wr_data),
    .mem_write(mem_write),
    .rd_data(rd_data),
    .inport0_data(inport0_data),
    .inport0_en(inport0_en),
    .inport1_data(inport1_data),
    .inport1_en(inport1_en),
    .outport(outport),
    .access_err(access_err)
  );

  typedef struct {
    logic [31:0] v;
    bit          known;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;

  logic [31:0] ram_m [256];
  bit          ram_k [256];
  logic [31:0] in0_m = '0;
  logic [31:0] in1_m = '0;
  logic [31:0] out_m = '0;
  logic        err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; model is advanced with the same inputs.
  task automatic step(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic r);
    exp_t        e;
    logic [31:0] wa;
    logic [7:0]  idx;
    bit          ramhit;
    addr      = a;
    mem_write = we;
    wr_data   = wd;
    rst       = r;
    wa        = {a[31:2], 2'b00};
    idx       = a[9:2];
    ramhit    = (a[31:10] == 22'd0);
    e.v       = '0;
    e.known   = 1'b1;
    if (r) begin
      out_m = '0;
      err_m = 1'b0;
      in0_m = '0;
      in1_m = '0;
    end else begin
      if (ramhit) begin
        e.v     = ram_m[idx];
        e.known = ram_k[idx];
      end else if (wa == IN0) begin
        e.v = in0_m;
      end else if (wa == IN1) begin
        e.v = in1_m;
      end
      if (a[1:0] != 2'b00 || !(ramhit || wa == IN0 || wa == IN1)) err_m = 1'b1;
      if (we) begin
        if (ramhit) begin
          ram_m[idx] = wd;
          ram_k[idx] = 1'b1;
        end else if (wa == IN1) begin
          out_m = wd;
        end
      end
      if (inport0_en) in0_m = inport0_data;
      if (inport1_en) in1_m = inport1_data;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.known) chk("rd_data", rd_data, e.v);
    chk("outport", outport, out_m);
    chk("access_err", {31'd0, access_err}, {31'd0, err_m});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_m[i] = '0;
      ram_k[i] = 1'b0;
    end
    rst          = 1'b1;
    addr         = '0;
    wr_data      = '0;
    mem_write    = 1'b0;
    inport0_data = '0;
    inport0_en   = 1'b0;
    inport1_data = '0;
    inport1_en   = 1'b0;

    // Reset, then idle reads of word 0
    step(32'h0, 1'b0, 32'h0, 1'b1);
    chk("reset_rd", rd_data, 32'h0);
    step(32'h0, 1'b0, 32'h0, 1'b0);
    step(32'h0, 1'b0, 32'h0, 1'b0);
    chk("idle_out", outport, 32'h0);

    // RAM write/read and read-before-write
    step(32'h10, 1'b1, 32'hDEADBEEF, 1'b0);
    step(32'h10, 1'b0, 32'h0, 1'b0);
    chk("ram_read", rd_data, 32'hDEADBEEF);
    step(32'h10, 1'b1, 32'h12345678, 1'b0);
    chk("rbw_old", rd_data, 32'hDEADBEEF);
    step(32'h10, 1'b0, 32'h0, 1'b0);
    chk("rbw_new", rd_data, 32'h12345678);

    // Input port 0 load, hold, and pre-load read
    inport0_data = 32'hA5; inport0_en = 1'b1;
    step(32'h10, 1'b0, 32'h0, 1'b0);
    inport0_data = 32'hFF; inport0_en = 1'b0;
    step(IN0, 1'b0, 32'h0, 1'b0);
    chk("in0_read", rd_data, 32'hA5);
    inport0_data = 32'h11; inport0_en = 1'b1;
    step(IN0, 1'b0, 32'h0, 1'b0);
    chk("in0_preload", rd_data, 32'hA5);
    inport0_en = 1'b0;
    step(IN0, 1'b0, 32'h0, 1'b0);
    chk("in0_loaded", rd_data, 32'h11);

    // Input port 1
    inport1_data = 32'h3C; inport1_en = 1'b1;
    step(32'h10, 1'b0, 32'h0, 1'b0);
    inport1_data = 32'hFF; inport1_en = 1'b0;
    step(IN1, 1'b0, 32'h0, 1'b0);
    chk("in1_read", rd_data, 32'h3C);

    // Output port write; readback shows inport1
    step(IN1, 1'b1, 32'h55, 1'b0);
    chk("outport_wr", outport, 32'h55);
    chk("wr_in1_rd", rd_data, 32'h3C);
    step(IN1, 1'b0, 32'h0, 1'b0);
    step(IN0, 1'b1, 32'h66, 1'b0);
    chk("in0_wr_out", outport, 32'h55);
    chk("in0_wr_err", {31'd0, access_err}, 32'h0);

    // Misaligned write lands on word 0x10 and sets the flag
    step(32'h12, 1'b1, 32'hCAFEF00D, 1'b0);
    chk("misalign_err", {31'd0, access_err}, 32'h1);
    step(32'h10, 1'b0, 32'h0, 1'b0);
    chk("misalign_word", rd_data, 32'hCAFEF00D);

    // Reset clears flag/outport/ports; then unmapped access is sticky
    step(32'h10, 1'b0, 32'h0, 1'b1);
    step(32'h2000, 1'b0, 32'h0, 1'b0);
    chk("unmapped_rd", rd_data, 32'h0);
    chk("unmapped_err", {31'd0, access_err}, 32'h1);
    step(32'h10, 1'b0, 32'h0, 1'b0);
    step(IN0, 1'b0, 32'h0, 1'b0);
    chk("in0_after_rst", rd_data, 32'h0);
    chk("err_sticky", {31'd0, access_err}, 32'h1);
    step(32'h2004, 1'b1, 32'h1, 1'b0);

    // Write during reset is suppressed
    step(32'h20, 1'b1, 32'h77, 1'b0);
    step(IN1, 1'b1, 32'hAA, 1'b0);
    step(32'h20, 1'b1, 32'h99, 1'b1);
    chk("rst_wr_rd", rd_data, 32'h0);
    chk("rst_wr_out", outport, 32'h0);
    chk("rst_wr_err", {31'd0, access_err}, 32'h0);
    step(32'h20, 1'b0, 32'h0, 1'b0);
    chk("rst_wr_kept", rd_data, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
